// File: rtl/lcd_spi_burst_writer.sv
// SPI write master for the ST7735R-class LCD path.
// Buffers {last,dc,payload} words in a small FIFO and shifts them out MSB-first,
// holding CS low across a burst until a word tagged last has been sent.
//
// state | meaning
// ------+-------------------------------------------------------------
// IDLE  | cs high, sclk at CPOL, waiting for a word in the FIFO
// SETUP | cs low, MSB on mosi, HALFDIV cycles before the first bit
// SHIFT | DATA_W bit periods of 2*HALFDIV cycles each
// HOLD  | mid-burst, FIFO empty: cs stays low, sclk at CPOL
// GAP   | burst closed: cs high for CS_GAP cycles before IDLE
module lcd_spi_burst_writer #(
    parameter int HALFDIV    = 2,
    parameter int DATA_W     = 8,
    parameter int FIFO_DEPTH = 16,
    parameter bit CPOL       = 1'b0,
    parameter bit CPHA       = 1'b0,
    parameter int CS_GAP     = 4
) (
    input  logic                          sys_clk,
    input  logic                          sys_rst_n,
    input  logic [DATA_W:0]               in_data,
    input  logic                          in_last,
    input  logic                          in_valid,
    output logic                          in_ready,
    output logic [$clog2(FIFO_DEPTH):0]   fifo_level,
    output logic                          busy,
    output logic                          wr_done,
    output logic                          cs,
    output logic                          dc,
    output logic                          sclk,
    output logic                          mosi
);

    localparam int PTR_W = $clog2(FIFO_DEPTH);
    localparam int LVL_W = PTR_W + 1;
    localparam int ENT_W = DATA_W + 2;
    localparam int HC_W  = (HALFDIV > 1) ? $clog2(HALFDIV) : 1;
    localparam int BC_W  = $clog2(DATA_W);
    localparam int GC_W  = (CS_GAP > 1) ? $clog2(CS_GAP) : 1;

    localparam logic [HC_W-1:0]  HC_LOAD = HC_W'(HALFDIV - 1);
    localparam logic [BC_W-1:0]  BC_LOAD = BC_W'(DATA_W - 1);
    localparam logic [GC_W-1:0]  GC_LOAD = GC_W'(CS_GAP - 1);
    localparam logic [LVL_W-1:0] LVL_FULL = LVL_W'(FIFO_DEPTH);

    typedef enum logic [2:0] {
        S_IDLE,
        S_SETUP,
        S_SHIFT,
        S_HOLD,
        S_GAP
    } state_t;

    logic [ENT_W-1:0]  mem [FIFO_DEPTH];
    logic [PTR_W-1:0]  wr_ptr;
    logic [PTR_W-1:0]  rd_ptr;
    logic [LVL_W-1:0]  level;
    logic              full;
    logic              empty;
    logic              push;
    logic              pop;
    logic [ENT_W-1:0]  head;

    state_t            state;
    logic [HC_W-1:0]   half_cnt;
    logic              phase_b;
    logic [BC_W-1:0]   bit_cnt;
    logic [GC_W-1:0]   gap_cnt;
    logic [DATA_W-2:0] shreg;
    logic              last_q;
    logic              word_end;

    assign full       = (level == LVL_FULL);
    assign empty      = (level == '0);
    assign in_ready   = !full;
    assign push       = in_valid && !full;
    assign head       = mem[rd_ptr];
    assign fifo_level = level;
    assign busy       = (state != S_IDLE) || !empty;

    // Final half-period of the final bit of the current word
    assign word_end = (state == S_SHIFT) && (half_cnt == '0) && phase_b && (bit_cnt == '0);

    // A new word is taken whenever the FSM is at a word boundary and the burst is still open
    assign pop = !empty && ((state == S_IDLE) || (state == S_HOLD) || (word_end && !last_q));

    // FIFO storage; contents need no reset since level gates every read
    always_ff @(posedge sys_clk) begin
        if (push) begin
            mem[wr_ptr] <= {in_last, in_data};
        end
    end

    // FIFO pointers and occupancy; full blocks a push even when a pop frees a slot
    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            level  <= '0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            if (push && !pop) begin
                level <= level + 1'b1;
            end else if (pop && !push) begin
                level <= level - 1'b1;
            end
        end
    end

    // Burst sequencer with registered pin outputs; a pop overrides the case's next state with a fresh load
    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            state    <= S_IDLE;
            half_cnt <= '0;
            phase_b  <= 1'b0;
            bit_cnt  <= '0;
            gap_cnt  <= '0;
            shreg    <= '0;
            last_q   <= 1'b0;
            cs       <= 1'b1;
            dc       <= 1'b0;
            sclk     <= CPOL;
            mosi     <= 1'b0;
            wr_done  <= 1'b0;
        end else begin
            wr_done <= 1'b0;
            case (state)
                S_IDLE: begin
                    cs   <= 1'b1;
                    sclk <= CPOL;
                end
                S_SETUP: begin
                    if (half_cnt == '0) begin
                        state    <= S_SHIFT;
                        half_cnt <= HC_LOAD;
                        phase_b  <= 1'b0;
                        bit_cnt  <= BC_LOAD;
                        sclk     <= CPOL ^ CPHA;
                    end else begin
                        half_cnt <= half_cnt - 1'b1;
                    end
                end
                S_SHIFT: begin
                    if (half_cnt != '0) begin
                        half_cnt <= half_cnt - 1'b1;
                    end else if (!phase_b) begin
                        phase_b  <= 1'b1;
                        half_cnt <= HC_LOAD;
                        sclk     <= ~(CPOL ^ CPHA);
                    end else if (bit_cnt == '0) begin
                        wr_done <= 1'b1;
                        sclk    <= CPOL;
                        if (last_q) begin
                            state   <= S_GAP;
                            cs      <= 1'b1;
                            gap_cnt <= GC_LOAD;
                        end else begin
                            state <= S_HOLD;
                        end
                    end else begin
                        bit_cnt  <= bit_cnt - 1'b1;
                        phase_b  <= 1'b0;
                        half_cnt <= HC_LOAD;
                        sclk     <= CPOL ^ CPHA;
                        mosi     <= shreg[DATA_W-2];
                        shreg    <= {shreg[DATA_W-3:0], 1'b0};
                    end
                end
                S_HOLD: begin
                    cs   <= 1'b0;
                    sclk <= CPOL;
                end
                S_GAP: begin
                    cs <= 1'b1;
                    if (gap_cnt == '0) begin
                        state <= S_IDLE;
                    end else begin
                        gap_cnt <= gap_cnt - 1'b1;
                    end
                end
                default: begin
                    state <= S_IDLE;
                    cs    <= 1'b1;
                    sclk  <= CPOL;
                end
            endcase

            if (pop) begin
                state    <= S_SETUP;
                half_cnt <= HC_LOAD;
                shreg    <= head[DATA_W-2:0];
                mosi     <= head[DATA_W-1];
                dc       <= head[DATA_W];
                last_q   <= head[DATA_W+1];
                cs       <= 1'b0;
                sclk     <= CPOL;
            end
        end
    end

endmodule

// File: tb/tb_lcd_spi_burst_writer.sv
// Directed bench for lcd_spi_burst_writer: mode 0 instance for bursts, flow control,
// HOLD and reset; mode 3 instance for clock polarity and data stability.
module tb_lcd_spi_burst_writer;

    logic       sys_clk = 1'b0;
    logic       sys_rst_n = 1'b0;

    logic [8:0] in_data_a = '0;
    logic       in_last_a = 1'b0;
    logic       in_valid_a = 1'b0;
    logic       in_ready_a;
    logic [4:0] level_a;
    logic       busy_a, wr_done_a, cs_a, dc_a, sclk_a, mosi_a;

    logic [8:0] in_data_b = '0;
    logic       in_last_b = 1'b0;
    logic       in_valid_b = 1'b0;
    logic       in_ready_b;
    logic [4:0] level_b;
    logic       busy_b, wr_done_b, cs_b, dc_b, sclk_b, mosi_b;

    always #5 sys_clk = ~sys_clk;

    lcd_spi_burst_writer u_dut (
        .sys_clk(sys_clk), .sys_rst_n(sys_rst_n),
        .in_data(in_data_a), .in_last(in_last_a), .in_valid(in_valid_a), .in_ready(in_ready_a),
        .fifo_level(level_a), .busy(busy_a), .wr_done(wr_done_a),
        .cs(cs_a), .dc(dc_a), .sclk(sclk_a), .mosi(mosi_a)
    );

    lcd_spi_burst_writer #(.CPOL(1'b1), .CPHA(1'b1)) u_dut_m3 (
        .sys_clk(sys_clk), .sys_rst_n(sys_rst_n),
        .in_data(in_data_b), .in_last(in_last_b), .in_valid(in_valid_b), .in_ready(in_ready_b),
        .fifo_level(level_b), .busy(busy_b), .wr_done(wr_done_b),
        .cs(cs_b), .dc(dc_b), .sclk(sclk_b), .mosi(mosi_b)
    );

    int checks = 0;
    int failures = 0;

    task automatic chk(input string tag, input int act, input int exp);
        checks++;
        if (act != exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, act, exp);
        end
    endtask

    // Line monitor, sampled 1 time unit after each rising sys_clk
    int   cyc = 0;
    int   rises_a = 0, wr_a = 0;
    bit   bits_a[$];
    bit   dcs_a[$];
    int   wr_t[$];
    logic ps_a = 1'b0;
    int   rises_b = 0, wr_b = 0, viol_b = 0;
    bit   bits_b[$];
    logic ps_b = 1'b1, pm_b = 1'b0;

    always begin
        @(posedge sys_clk);
        #1;
        cyc++;
        if (!ps_a && sclk_a) begin
            rises_a++;
            bits_a.push_back(mosi_a);
            dcs_a.push_back(dc_a);
        end
        ps_a = sclk_a;
        if (wr_done_a) begin
            wr_a++;
            wr_t.push_back(cyc);
        end
        if (!ps_b && sclk_b) begin
            rises_b++;
            bits_b.push_back(mosi_b);
        end
        if (sclk_b && !cs_b && (mosi_b !== pm_b)) viol_b++;
        ps_b = sclk_b;
        pm_b = mosi_b;
        if (wr_done_b) wr_b++;
    end

    function automatic int byte_a(input int s);
        int v = 0;
        for (int i = 0; i < 8; i++) v = (v << 1) | int'(bits_a[s+i]);
        return v;
    endfunction

    function automatic int byte_b(input int s);
        int v = 0;
        for (int i = 0; i < 8; i++) v = (v << 1) | int'(bits_b[s+i]);
        return v;
    endfunction

    task automatic push_a(input logic [8:0] d, input logic l);
        @(negedge sys_clk);
        in_valid_a = 1'b1;
        in_data_a  = d;
        in_last_a  = l;
        @(negedge sys_clk);
        in_valid_a = 1'b0;
        in_last_a  = 1'b0;
    endtask

    task automatic wait_wr_a(input int target, input string tag);
        int n = 0;
        while (wr_a < target && n < 2000) begin
            @(negedge sys_clk);
            n++;
        end
        chk(tag, int'(wr_a >= target), 1);
    endtask

    int r0, b0, w0, t0, nb, nh, n, bad, maxlvl, idx, viol, v0;
    logic [8:0] words [20];
    logic rdy;
    logic [4:0] lvl;
    bit saw_block;

    initial begin
        repeat (3) @(negedge sys_clk);
        chk("rst_cs", cs_a, 1);
        chk("rst_sclk", sclk_a, 0);
        chk("rst_mosi", mosi_a, 0);
        chk("rst_dc", dc_a, 0);
        chk("rst_wr_done", wr_done_a, 0);
        chk("rst_level", level_a, 0);
        chk("rst_ready", in_ready_a, 1);
        chk("rst_busy", busy_a, 0);
        chk("rst_m3_sclk", sclk_b, 1);
        sys_rst_n = 1'b1;
        repeat (2) @(negedge sys_clk);

        // Single word, last=1
        r0 = rises_a; b0 = bits_a.size(); w0 = wr_a;
        push_a(9'h1A5, 1'b1);
        chk("t1_cs_t1", cs_a, 1);
        @(negedge sys_clk);
        chk("t1_cs_t2", cs_a, 0);
        chk("t1_dc", dc_a, 1);
        wait_wr_a(w0 + 1, "t1_wr_seen");
        nb = 0; nh = 0;
        for (int k = 0; k < 8; k++) begin
            if (busy_a) nb++;
            if (cs_a) nh++;
            @(negedge sys_clk);
        end
        chk("t1_busy_in_gap", nb, 4);
        chk("t1_cs_high", nh, 8);
        chk("t1_rises", rises_a - r0, 8);
        chk("t1_bits", byte_a(b0), 'hA5);
        chk("t1_wr_count", wr_a - w0, 1);

        // Three-word burst pushed back to back
        r0 = rises_a; b0 = bits_a.size(); w0 = wr_a; t0 = wr_t.size();
        @(negedge sys_clk);
        in_valid_a = 1'b1; in_data_a = 9'h011; in_last_a = 1'b0;
        @(negedge sys_clk);
        in_data_a = 9'h122;
        @(negedge sys_clk);
        in_data_a = 9'h033; in_last_a = 1'b1;
        @(negedge sys_clk);
        in_valid_a = 1'b0; in_last_a = 1'b0;
        n = 0;
        while (cs_a && n < 20) begin @(negedge sys_clk); n++; end
        nh = 0; n = 0;
        while (wr_a < w0 + 3 && n < 400) begin
            if (cs_a) nh++;
            @(negedge sys_clk);
            n++;
        end
        chk("t2_wr_count", wr_a - w0, 3);
        chk("t2_cs_high_in_burst", nh, 0);
        chk("t2_rises", rises_a - r0, 24);
        chk("t2_byte0", byte_a(b0), 'h11);
        chk("t2_byte1", byte_a(b0 + 8), 'h22);
        chk("t2_byte2", byte_a(b0 + 16), 'h33);
        chk("t2_dc0", dcs_a[b0], 0);
        chk("t2_dc1", dcs_a[b0 + 8], 1);
        chk("t2_dc2", dcs_a[b0 + 16], 0);
        chk("t2_spacing01", wr_t[t0 + 1] - wr_t[t0], 34);
        chk("t2_spacing12", wr_t[t0 + 2] - wr_t[t0 + 1], 34);
        repeat (10) @(negedge sys_clk);

        // Twenty words offered every cycle: FIFO must fill and stall the producer
        for (int i = 0; i < 20; i++) words[i] = {i[0], 8'(i * 37 + 11)};
        r0 = rises_a; b0 = bits_a.size(); w0 = wr_a;
        idx = 0; n = 0; maxlvl = 0; bad = 0; saw_block = 1'b0;
        @(negedge sys_clk);
        while (idx < 20 && n < 300) begin
            in_valid_a = 1'b1;
            in_data_a  = words[idx];
            in_last_a  = (idx == 19);
            rdy = in_ready_a;
            lvl = level_a;
            if (int'(lvl) > maxlvl) maxlvl = int'(lvl);
            if (rdy != (lvl != 5'd16)) bad++;
            if (!rdy) saw_block = 1'b1;
            @(negedge sys_clk);
            n++;
            if (rdy) idx++;
        end
        in_valid_a = 1'b0; in_last_a = 1'b0;
        chk("t3_all_pushed", idx, 20);
        chk("t3_max_level", maxlvl, 16);
        chk("t3_ready_vs_level", bad, 0);
        chk("t3_saw_block", int'(saw_block), 1);
        wait_wr_a(w0 + 20, "t3_wr_seen");
        chk("t3_rises", rises_a - r0, 160);
        bad = 0;
        for (int i = 0; i < 20; i++) if (byte_a(b0 + 8 * i) != int'(words[i][7:0])) bad++;
        chk("t3_bytes_wrong", bad, 0);
        repeat (10) @(negedge sys_clk);

        // Burst split by a long producer stall
        r0 = rises_a; b0 = bits_a.size(); w0 = wr_a;
        push_a(9'h0C3, 1'b0);
        wait_wr_a(w0 + 1, "t4_wr1_seen");
        viol = 0;
        for (int k = 0; k < 60; k++) begin
            if (cs_a || sclk_a) viol++;
            @(negedge sys_clk);
        end
        chk("t4_hold_pins", viol, 0);
        chk("t4_hold_busy", busy_a, 1);
        push_a(9'h13C, 1'b1);
        wait_wr_a(w0 + 2, "t4_wr2_seen");
        chk("t4_wr_count", wr_a - w0, 2);
        chk("t4_byte0", byte_a(b0), 'hC3);
        chk("t4_byte1", byte_a(b0 + 8), 'h3C);
        repeat (10) @(negedge sys_clk);

        // Mode 3 instance
        chk("t5_idle_sclk", sclk_b, 1);
        r0 = rises_b; b0 = bits_b.size(); w0 = wr_b; v0 = viol_b;
        @(negedge sys_clk);
        in_valid_b = 1'b1; in_data_b = 9'h03C; in_last_b = 1'b1;
        @(negedge sys_clk);
        in_valid_b = 1'b0; in_last_b = 1'b0;
        n = 0;
        while (wr_b < w0 + 1 && n < 200) begin @(negedge sys_clk); n++; end
        chk("t5_wr_count", wr_b - w0, 1);
        chk("t5_rises", rises_b - r0, 8);
        chk("t5_bits", byte_b(b0), 'h3C);
        chk("t5_mosi_unstable_high", viol_b - v0, 0);
        repeat (6) @(negedge sys_clk);
        chk("t5_idle_sclk_after", sclk_b, 1);

        // Reset in the middle of bit 4
        r0 = rises_a;
        push_a(9'h0FF, 1'b0);
        push_a(9'h0AA, 1'b1);
        n = 0;
        while (rises_a - r0 < 4 && n < 100) begin @(negedge sys_clk); n++; end
        chk("t6_mid_bit4", rises_a - r0, 4);
        chk("t6_level_pre", level_a, 1);
        sys_rst_n = 1'b0;
        #1;
        chk("t6_cs", cs_a, 1);
        chk("t6_sclk", sclk_a, 0);
        chk("t6_level", level_a, 0);
        chk("t6_busy", busy_a, 0);
        @(negedge sys_clk);
        sys_rst_n = 1'b1;
        repeat (2) @(negedge sys_clk);
        r0 = rises_a; b0 = bits_a.size(); w0 = wr_a;
        push_a(9'h155, 1'b1);
        wait_wr_a(w0 + 1, "t6_wr_seen");
        chk("t6_rises", rises_a - r0, 8);
        chk("t6_bits", byte_a(b0), 'h55);
        chk("t6_dc", dcs_a[b0], 1);
        repeat (8) @(negedge sys_clk);
        chk("t6_idle_after", busy_a, 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
